// File: rtl/main_func_udiv_15ns_9ns_15_seq_1_if.sv
// Start/done handshake and operand/result bundle for the sequential
// 15-by-9 unsigned divider. The FSM side drives the master modport and the
// divider core sits on the slave modport.
interface main_func_udiv_15ns_9ns_15_seq_1_if #(
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 15
);
  logic                  ce;
  logic                  start;
  logic                  ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  done;
  logic [dout_WIDTH-1:0] quot;
  logic [din1_WIDTH-1:0] rem;
  logic                  div_by_zero;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, quot, rem, div_by_zero
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, quot, rem, div_by_zero
  );
endinterface

// File: rtl/main_func_udiv_15ns_9ns_15_seq_1.sv
// Sequential unsigned restoring divider: 15-bit dividend / 9-bit divisor,
// one quotient bit per enabled clock. Operands are captured on accept, the
// quotient is built in place inside the dividend shift register, and the
// registered results only change on the final iteration.
module main_func_udiv_15ns_9ns_15_seq_1 #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 15
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst,
  main_func_udiv_15ns_9ns_15_seq_1_if.slave bus
);

  localparam int               CNT_W    = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(din0_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // dividend bits leave at the MSB while quotient bits enter at the LSB
  logic [din0_WIDTH-1:0] dq_q, dq_d;
  logic [din1_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [din1_WIDTH-1:0] pr_q, pr_d;
  logic                  dz_q, dz_d;
  logic [dout_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [din1_WIDTH:0]   pr_shift;
  logic                  pr_ge;
  logic [din1_WIDTH-1:0] pr_sub;
  logic [din1_WIDTH-1:0] pr_next;
  logic [din0_WIDTH-1:0] dq_next;

  // one restoring step: shift in the next dividend bit, subtract if it fits.
  // The subtraction result is always below the divisor, so the low
  // din1_WIDTH bits of the wrapped difference are exact. With a zero divisor
  // every step "fits", so the quotient fills with ones and the remainder
  // ends up holding the low din1_WIDTH bits of the dividend.
  always_comb begin
    pr_shift = {pr_q, dq_q[din0_WIDTH-1]};
    pr_ge    = (pr_shift >= {1'b0, dvsr_q});
    pr_sub   = pr_shift[din1_WIDTH-1:0] - dvsr_q;
    pr_next  = pr_ge ? pr_sub : pr_shift[din1_WIDTH-1:0];
    dq_next  = {dq_q[din0_WIDTH-2:0], pr_ge};
  end

  // FSM next state, iteration datapath and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvsr_d  = dvsr_q;
    pr_d    = pr_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ce && bus.start) begin
          dq_d    = bus.din0;
          dvsr_d  = bus.din1;
          dz_d    = (bus.din1 == '0);
          pr_d    = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.ce) begin
          pr_d  = pr_next;
          dq_d  = dq_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            quot_d  = dz_q ? '1 : dout_WIDTH'(dq_next);
            rem_d   = pr_next;
            dbz_d   = dz_q;
          end
        end
      end
      S_DONE: begin
        if (bus.ce) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control and result registers; results clear so outputs read zero after reset
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // working registers are reloaded on every accept, so they need no reset
  always_ff @(posedge ap_clk) begin
    dq_q   <= dq_d;
    dvsr_q <= dvsr_d;
    pr_q   <= pr_d;
    dz_q   <= dz_d;
  end

  assign bus.ready       = (state_q == S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
